frame_sync_controller: RTL and testbench
========================================

// Module: frame_sync_controller
// PURPOSE
//  Sequences the receive bit shift register behind the BPSK demodulator: shifts in sliced bits on
//  bit_valid, hunts for a fixed sync word, then frames PAYLOAD_BYTES payload bytes MSB-first.
//  Presents the bytes on a valid/ready stream to the packet layer. Sits between symbol slicer and deframer.
// PARAMETERS
//  SYNC_LEN       16        sync word length in bits (8..32)
//  SYNC_WORD      16'hF628  sync pattern, MSB received first
//  PAYLOAD_BYTES  4         bytes per frame after sync (1..255)
//  MAX_ERR        1         bit mismatches tolerated in sync (only with SYNC_ERR_TOLERANCE_EN)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  bit_in       in   1  sliced bit, sampled only when bit_valid=1
//  bit_valid    in   1  one-cycle strobe per received bit
//  byte_out     out  8  payload byte, first received bit in [7]
//  byte_valid   out  1  byte_out valid; held until byte_ready
//  byte_ready   in   1  downstream accepts byte when byte_valid&&byte_ready
//  frame_start  out  1  one-cycle pulse on sync detection
//  frame_end    out  1  high with byte_valid of the last payload byte
//  locked       out  1  high from sync detection until last byte accepted or abort
//  overflow     out  1  one-cycle pulse when a byte completes while previous byte not yet accepted
// BEHAVIOUR
//  Reset: all outputs 0, window cleared, state HUNT, counters 0. Async assert; deassert synced to clk.
//  States: HUNT -> LOCK -> HUNT.
//  HUNT: each bit_valid shifts bit_in into LSB of SYNC_LEN window (window <= {window,bit_in}).
//   Match compared on the combinational next-window value; on match: state LOCK, frame_start=1 and
//   locked=1 the cycle after that bit_valid; window cleared; bit_cnt=0, byte_cnt=0.
//  LOCK: each bit_valid shifts into an 8-bit byte register; bit_cnt 0..7 wraps. On 8th bit,
//   byte_out/byte_valid register the cycle after that bit_valid (latency 1). byte_cnt increments.
//   Last byte (byte_cnt==PAYLOAD_BYTES-1): frame_end=1 alongside byte_valid; locked drops and state
//   returns to HUNT the cycle after handshake completes; bits arriving meanwhile go to the HUNT window.
//  Handshake: byte_valid held stable with byte_out until byte_valid&&byte_ready; cleared next cycle
//   unless a new byte completes in the same cycle (then reloaded, valid stays high, no overflow).
//  Overflow: byte completes while byte_valid&&!byte_ready -> overflow pulse, pending and new byte
//   dropped, byte_valid=0, frame_end=0, locked=0, state HUNT, window cleared.
//  bit_valid when not in HUNT/LOCK is impossible; bit_valid held high every cycle is legal.
//  Sync never matched inside LOCK (payload containing SYNC_WORD is not re-synced).
//  Reset mid-frame: immediate abort, all outputs 0, no frame_end.
// CONFIGURATION
//  SYNC_ERR_TOLERANCE_EN defined: match when popcount(next_window ^ SYNC_WORD) <= MAX_ERR, evaluated
//   only after SYNC_LEN bits shifted since last clear. Undefined: exact compare only, MAX_ERR ignored.
// STRUCTURE
//  Package bpsk_frame_pkg: state enum fsync_state_t {HUNT,LOCK}, BYTE_W=8, default SYNC_WORD constant.
//  Sub-module sync_shift_reg#(LEN): shift register with shift-enable, sync clear, next-value output;
//   instantiated for the window. Byte assembly and FSM in this module.
// TESTING
//  1) Reset, bits 0xF628 then 0x12,0x34,0x56,0x78, ready=1 -> frame_start 1 cyc after 16th bit; bytes
//     0x12,0x34,0x56,0x78 each 1 cyc after 8th bit; frame_end with 0x78; locked low after.
//  2) 5 random bits then sync + payload, bit_valid every cycle -> match on exact alignment only.
//  3) byte_ready=0 through 2nd byte -> overflow pulse on 16th payload bit, byte_valid=0, locked=0,
//     HUNT; subsequent sync frames normally.
//  4) Payload byte pair 0xF6,0x28 -> no second frame_start; 4 bytes delivered.
//  5) rst asserted after 2nd payload byte mid-handshake -> all outputs 0 same cycle; next frame OK.
//  6) SYNC_ERR_TOLERANCE_EN: sync 0xF629 (1 err) locks; 0xF62B (2 err) does not; without macro neither.

Source files
------------

// File: rtl/bpsk_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_frame_pkg
// Description : Shared types and constants for the BPSK receive frame sync
//               path: FSM state encoding, byte width, default sync word and a
//               popcount helper used by the error-tolerant sync compare.
// Revision    : 1.0 - initial release
// ============================================================================
package bpsk_frame_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } fsync_state_t;

    localparam int BYTE_W = 8;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF628;

    // Number of set bits in a 32-bit vector; narrower operands are zero-extended.
    function automatic int unsigned popcount32(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_sync_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_sync_controller_if
// Description : Bit input strobe and byte output stream bundle of the frame
//               sync controller.
//               master : upstream slicer / downstream packet layer side
//               slave  : the controller itself
//               bit_in/bit_valid   - sliced bit and its one-cycle strobe
//               byte_out/byte_valid/byte_ready - payload byte stream
//               frame_start/frame_end/locked/overflow - framing status
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_sync_controller_if;
    import bpsk_frame_pkg::*;

    logic              bit_in;
    logic              bit_valid;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic              frame_start;
    logic              frame_end;
    logic              locked;
    logic              overflow;

    modport master (
        output bit_in, bit_valid, byte_ready,
        input  byte_out, byte_valid, frame_start, frame_end, locked, overflow
    );

    modport slave (
        input  bit_in, bit_valid, byte_ready,
        output byte_out, byte_valid, frame_start, frame_end, locked, overflow
    );

endinterface
`default_nettype wire

// File: rtl/sync_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : sync_shift_reg
// Description : Sync-word hunting window. Shifts bit_i into the LSB on
//               shift_en_i; clr_i (priority) empties the window. next_o is the
//               window value including the bit currently being offered.
//               Ports: clk, rst (async, active-high), shift_en_i, clr_i,
//               bit_i, next_o[LEN-1:0].
// Revision    : 1.0 - initial release
// ============================================================================
module sync_shift_reg #(
    parameter int LEN = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           shift_en_i,
    input  wire logic           clr_i,
    input  wire logic           bit_i,
    output logic [LEN-1:0]      next_o
);

    // Only LEN-1 older bits are retained: the oldest bit of a full window is
    // shifted out on the very shift that would need it again.
    logic [LEN-2:0] win_q;

    assign next_o = {win_q, bit_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (clr_i) begin
            win_q <= '0;
        end else if (shift_en_i) begin
            win_q <= next_o[LEN-2:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_sync_controller.sv
`default_nettype none
// ============================================================================
// Module      : frame_sync_controller
// Description : Receive bit sequencer behind the BPSK demodulator. Hunts for
//               SYNC_WORD in the incoming bit stream, then assembles
//               PAYLOAD_BYTES bytes MSB-first and presents them on a
//               valid/ready stream with frame status flags.
//               Ports: clk, rst (async assert, active-high; deassertion is
//               expected to be synchronised upstream), bus (slave modport of
//               frame_sync_controller_if).
//               Optional build macro SYNC_ERR_TOLERANCE_EN: accept the sync
//               word with up to MAX_ERR bit errors once a full window of bits
//               has been shifted since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sync_controller
    import bpsk_frame_pkg::*;
#(
    parameter int                  SYNC_LEN      = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD     = SYNC_LEN'(DEFAULT_SYNC_WORD),
    parameter int                  PAYLOAD_BYTES = 4,
    parameter int                  MAX_ERR       = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    frame_sync_controller_if.slave  bus
);

`ifdef SYNC_ERR_TOLERANCE_EN
    localparam int unsigned c_TOL = 32'(MAX_ERR);
`else
    // Tolerance disabled: zero allowed errors is an exact compare.
    localparam int unsigned c_TOL = 32'(MAX_ERR * 0);
`endif

    fsync_state_t       state_q;
    logic [BYTE_W-2:0]  shreg_q;
    logic [BYTE_W-1:0]  byte_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         byte_cnt_q;
    logic               byte_valid_q;
    logic               frame_start_q;
    logic               frame_end_q;
    logic               locked_q;
    logic               overflow_q;
    // Last byte assembled, waiting for its handshake; bits now feed the window.
    logic               drain_q;

    logic [SYNC_LEN-1:0] win_d;
    logic [BYTE_W-1:0]   w_byte_next;
    logic                w_win_shift;
    logic                w_win_clr;
    logic                w_window_full;
    logic                w_sync_hit;
    logic                w_byte_done;
    logic                w_overrun;
    logic                w_accept;

`ifdef SYNC_ERR_TOLERANCE_EN
    // Shifts since last clear, saturating at SYNC_LEN.
    logic [5:0] fill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
        end else if (w_win_clr) begin
            fill_q <= '0;
        end else if (w_win_shift && (fill_q != 6'(SYNC_LEN))) begin
            fill_q <= fill_q + 6'd1;
        end
    end

    assign w_window_full = (fill_q >= 6'(SYNC_LEN - 1));
`else
    assign w_window_full = 1'b1;
`endif

    always_comb begin
        w_byte_next = {shreg_q, bus.bit_in};
        w_accept    = byte_valid_q && bus.byte_ready;
        w_win_shift = bus.bit_valid && ((state_q == HUNT) || drain_q);
        w_sync_hit  = (state_q == HUNT) && bus.bit_valid && w_window_full &&
                      (popcount32(32'(win_d ^ SYNC_WORD)) <= c_TOL);
        w_byte_done = (state_q == LOCK) && bus.bit_valid && !drain_q &&
                      (bit_cnt_q == 3'd7);
        w_overrun   = w_byte_done && byte_valid_q && !bus.byte_ready;
        w_win_clr   = w_sync_hit || w_overrun;
    end

    sync_shift_reg #(
        .LEN        (SYNC_LEN)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (w_win_shift),
        .clr_i      (w_win_clr),
        .bit_i      (bus.bit_in),
        .next_o     (win_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            shreg_q       <= '0;
            byte_q        <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            locked_q      <= 1'b0;
            overflow_q    <= 1'b0;
            drain_q       <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;

            if (w_accept) begin
                byte_valid_q <= 1'b0;
                frame_end_q  <= 1'b0;
                if (frame_end_q) begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                    drain_q  <= 1'b0;
                end
            end

            // Byte completion below overrides the handshake clear above, so a
            // byte finishing in the accept cycle reloads with valid held high.
            case (state_q)
                HUNT: begin
                    if (w_sync_hit) begin
                        state_q       <= LOCK;
                        frame_start_q <= 1'b1;
                        locked_q      <= 1'b1;
                        bit_cnt_q     <= '0;
                        byte_cnt_q    <= '0;
                    end
                end
                LOCK: begin
                    if (bus.bit_valid && !drain_q) begin
                        shreg_q   <= w_byte_next[BYTE_W-2:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (w_overrun) begin
                            overflow_q   <= 1'b1;
                            byte_valid_q <= 1'b0;
                            frame_end_q  <= 1'b0;
                            locked_q     <= 1'b0;
                            state_q      <= HUNT;
                        end else if (w_byte_done) begin
                            byte_q       <= w_byte_next;
                            byte_valid_q <= 1'b1;
                            byte_cnt_q   <= byte_cnt_q + 8'd1;
                            if (byte_cnt_q == 8'(PAYLOAD_BYTES - 1)) begin
                                frame_end_q <= 1'b1;
                                drain_q     <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign bus.byte_out    = byte_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.locked      = locked_q;
    assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sync_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sync_controller
// Description : Directed self-checking bench for frame_sync_controller.
//               Inputs change 1 ns after the rising edge; outputs are read at
//               the same point, i.e. after the registered response to the bit
//               sampled on that edge. Optional macro SYNC_ERR_TOLERANCE_EN
//               selects the tolerant-sync expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sync_controller;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef SYNC_ERR_TOLERANCE_EN
    localparam logic c_TOL_EN = 1'b1;
`else
    localparam logic c_TOL_EN = 1'b0;
`endif

    frame_sync_controller_if bus();

    frame_sync_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Back-to-back calls keep bit_valid high on every edge.
    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_sync(input logic [15:0] w, input logic exp_lock, input string tag);
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0) chk($sformatf("%s_early_fs%0d", tag, i), 32'(bus.frame_start), 32'd0);
        end
        chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'(exp_lock));
        chk({tag, "_locked"}, 32'(bus.locked), 32'(exp_lock));
    endtask

    // Four payload bytes with byte_ready held high.
    task automatic recv_frame(input logic [31:0] p, input string tag);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = p[31 - 8*k -: 8];
            for (int i = 7; i >= 0; i--) begin
                send_bit(b[i]);
                chk($sformatf("%s_b%0d_nofs", tag, k), 32'(bus.frame_start), 32'd0);
            end
            chk($sformatf("%s_b%0d_valid", tag, k), 32'(bus.byte_valid), 32'd1);
            chk($sformatf("%s_b%0d_data", tag, k), 32'(bus.byte_out), 32'(b));
            chk($sformatf("%s_b%0d_fend", tag, k), 32'(bus.frame_end), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s_b%0d_locked", tag, k), 32'(bus.locked), 32'd1);
        end
        idle(1);
        chk({tag, "_end_valid"}, 32'(bus.byte_valid), 32'd0);
        chk({tag, "_end_fend"}, 32'(bus.frame_end), 32'd0);
        chk({tag, "_end_locked"}, 32'(bus.locked), 32'd0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.byte_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Reset state
        chk("rst_byte_out", 32'(bus.byte_out), 32'd0);
        chk("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        chk("rst_frame_end", 32'(bus.frame_end), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);

        // 1) Basic frame; idle gap between sync and payload
        send_sync(16'hF628, 1'b1, "t1");
        idle(1);
        chk("t1_fs_one_cycle", 32'(bus.frame_start), 32'd0);
        chk("t1_locked_held", 32'(bus.locked), 32'd1);
        idle(1);
        recv_frame(32'h12345678, "t1");

        // 2) Misaligned prefix, bit_valid every cycle
        send_bit(1'b1); chk("t2_pre0", 32'(bus.frame_start), 32'd0);
        send_bit(1'b0); chk("t2_pre1", 32'(bus.frame_start), 32'd0);
        send_bit(1'b1); chk("t2_pre2", 32'(bus.frame_start), 32'd0);
        send_bit(1'b1); chk("t2_pre3", 32'(bus.frame_start), 32'd0);
        send_bit(1'b0); chk("t2_pre4", 32'(bus.frame_start), 32'd0);
        send_sync(16'hF628, 1'b1, "t2");
        recv_frame(32'hA55A00FF, "t2");

        // 3) Overflow: second byte completes while first is still pending
        bus.byte_ready = 1'b0;
        send_sync(16'hF628, 1'b1, "t3");
        send_byte(8'h11);
        chk("t3_b0_valid", 32'(bus.byte_valid), 32'd1);
        chk("t3_b0_data", 32'(bus.byte_out), 32'h11);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("t3_hold_valid", 32'(bus.byte_valid), 32'd1);
        chk("t3_hold_data", 32'(bus.byte_out), 32'h11);
        chk("t3_no_ovf_yet", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        chk("t3_ovf_pulse", 32'(bus.overflow), 32'd1);
        chk("t3_ovf_valid", 32'(bus.byte_valid), 32'd0);
        chk("t3_ovf_locked", 32'(bus.locked), 32'd0);
        chk("t3_ovf_fend", 32'(bus.frame_end), 32'd0);
        idle(1);
        chk("t3_ovf_one_cycle", 32'(bus.overflow), 32'd0);
        bus.byte_ready = 1'b1;
        send_sync(16'hF628, 1'b1, "t3r");
        recv_frame(32'hDEADBEEF, "t3r");

        // 4) Sync word inside payload must not re-sync
        send_sync(16'hF628, 1'b1, "t4");
        recv_frame(32'hF6280102, "t4");

        // 5) Reset mid-handshake
        send_sync(16'hF628, 1'b1, "t5");
        send_byte(8'hC3);
        chk("t5_b0_data", 32'(bus.byte_out), 32'hC3);
        send_byte(8'h3C);
        chk("t5_b1_data", 32'(bus.byte_out), 32'h3C);
        bus.byte_ready = 1'b0;
        idle(1);
        chk("t5_b1_held", 32'(bus.byte_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_byte_out", 32'(bus.byte_out), 32'd0);
        chk("t5_rst_valid", 32'(bus.byte_valid), 32'd0);
        chk("t5_rst_locked", 32'(bus.locked), 32'd0);
        chk("t5_rst_fend", 32'(bus.frame_end), 32'd0);
        chk("t5_rst_fs", 32'(bus.frame_start), 32'd0);
        chk("t5_rst_ovf", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.byte_ready = 1'b1;
        send_sync(16'hF628, 1'b1, "t5r");
        recv_frame(32'h0F1E2D3C, "t5r");

        // 6) Sync words with one and two bit errors
        do_reset();
        send_sync(16'hF629, c_TOL_EN, "t6_1err");
        do_reset();
        send_sync(16'hF62B, 1'b0, "t6_2err");
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
